sar_search: RTL and testbench
=============================

Name: sar_search

Overview:
- Bit-serial successive-approximation search engine that finds an unknown WIDTH-bit target.
- It drives the A-side operand of an external combinational magnitude comparator with trial values, one per cycle; the target sits on the comparator's B side.
- It consumes the comparator's three relation outputs (A>B, A=B, A<B) and converges MSB-first, with early exit on equality.
- It is the controlling end of the comparator interface: the comparator reports the relation, and this block acts on it.

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..16.
- SW, 5, width of the step counter; must satisfy 2^SW > WIDTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a search; sampled in IDLE only.
- cmp_gt  input  1  comparator Y2: guess > target.
- cmp_eq  input  1  comparator Y1: guess = target.
- cmp_lt  input  1  comparator Y0: guess < target.
- guess  output  WIDTH  trial value driven to the comparator A input.
- busy  output  1  high while in SEARCH.
- done  output  1  one-cycle pulse when a search terminates (success or error).
- result  output  WIDTH  resolved target value; held until the next start.
- err  output  1  search aborted on inconsistent comparator response; held until the next start.
- steps  output  SW  number of compare cycles used by the last search.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - guess = 0, result = 0, steps = 0.
  - busy = 0, done = 0, err = 0.
- States: IDLE, SEARCH, FIN.
- Internal registers: prefix[WIDTH-1:0] and bit_idx.

IDLE:
- guess = 0.
- start = 1 -> SEARCH next cycle, with:
  - prefix = 0, bit_idx = WIDTH-1.
  - guess = 1 << (WIDTH-1).
  - err = 0, steps = 0, busy = 1.

SEARCH, one compare per cycle:
- guess is a register, so it is stable for the whole cycle. cmp_* are sampled at the end of the same cycle (the external comparator is combinational).
- Each SEARCH cycle increments steps by 1.
- Exactly one of cmp_gt/eq/lt high is legal. Zero or more than one high -> err = 1, result = 0, go to FIN.
- cmp_eq -> result = guess, go to FIN.
- cmp_lt:
  - bit_idx > 0: keep the bit, so prefix = guess.
  - bit_idx == 0: inconsistent (target cannot exceed prefix|1) -> err = 1, result = 0, go to FIN.
- cmp_gt:
  - bit_idx > 0: clear the bit, so prefix is unchanged.
  - bit_idx == 0: result = prefix, go to FIN.
- If not going to FIN: bit_idx decrements, and guess = new prefix | (1 << new bit_idx).

FIN:
- done = 1 for exactly this cycle.
- busy = 0, guess = 0.
- Next state is unconditionally IDLE.

Timing and boundaries:
- Latency: start sampled at edge E0. First compare occurs in cycle E0+1. done pulses one cycle after the terminating compare.
- Maximum steps = WIDTH; minimum = 1 (target = 2^(WIDTH-1)).
- start while in SEARCH or FIN is ignored; no restart and no queuing.
- start in the same cycle as rst: rst wins.
- start held high continuously: a new search begins in the IDLE cycle after FIN, so there are back-to-back searches with one idle cycle between them.
- rst mid-search: all outputs return to reset values on the next edge. done is not pulsed.
- result, err and steps are updated only at termination and hold through IDLE.
- Arithmetic: pure bit set/clear; no adders apart from the steps increment, which cannot overflow given the SW constraint.

Test Plan:
- WIDTH=4, bench comparator with target=5:
  - guess sequence 8, 4, 6, 5.
  - done pulses after the 4th compare; result=5, steps=4, err=0.
- target=8 -> single compare (guess 8, eq) -> result=8, steps=1, done 2 cycles after the start edge.
- target=0 -> guesses 8, 4, 2, 1, all gt -> result=0, steps=4. target=15 -> guesses 8, 12, 14, 15 -> result=15, steps=4.
- Forced illegal responses:
  - cmp_gt=cmp_lt=1 on the 2nd compare -> err=1, result=0, steps=2, done pulse.
  - All cmp inputs low on the 1st compare -> err=1.
  - lt on the bit-0 compare -> err=1.
- Sweep all 16 targets with start held high -> every search returns result=target, err=0, one IDLE cycle between searches. A start pulse mid-search is ignored: guess sequence unchanged.
- rst asserted on the 3rd SEARCH cycle of target=5 -> next cycle all outputs are 0, no done pulse. A new start then completes normally with result=5.

Source files
------------

// File: rtl/sar_search.sv
// Successive-approximation search engine: drives trial values onto the A side of an
// external combinational comparator and resolves the B-side target MSB-first.
module sar_search #(
    parameter int WIDTH = 4,
    parameter int SW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cmp_gt,
    input  logic             cmp_eq,
    input  logic             cmp_lt,
    output logic [WIDTH-1:0] guess,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic [SW-1:0]    steps
);

    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEARCH,
        S_FIN
    } state_t;

    state_t           r_state, w_state_next;
    logic [WIDTH-1:0] r_prefix, w_prefix_next;
    logic [IW-1:0]    r_bit_idx, w_bit_idx_next;
    logic [WIDTH-1:0] r_guess, w_guess_next;
    logic [WIDTH-1:0] r_result, w_result_next;
    logic [SW-1:0]    r_steps, w_steps_next;
    logic             r_busy, w_busy_next;
    logic             r_done, w_done_next;
    logic             r_err, w_err_next;

    logic             w_legal;
    logic             w_finish;
    logic [IW-1:0]    w_idx_dec;
    logic [WIDTH-1:0] w_bit_dec;
    logic [WIDTH-1:0] w_kept_prefix;

    // Exactly one relation high: odd count of ones, but not all three.
    assign w_legal       = (cmp_gt ^ cmp_eq ^ cmp_lt) & ~(cmp_gt & cmp_eq & cmp_lt);
    assign w_idx_dec     = r_bit_idx - IW'(1);
    assign w_bit_dec     = {{(WIDTH-1){1'b0}}, 1'b1} << w_idx_dec;
    assign w_kept_prefix = cmp_lt ? r_guess : r_prefix;

    always_comb begin
        w_state_next   = r_state;
        w_prefix_next  = r_prefix;
        w_bit_idx_next = r_bit_idx;
        w_guess_next   = r_guess;
        w_result_next  = r_result;
        w_steps_next   = r_steps;
        w_busy_next    = r_busy;
        w_done_next    = 1'b0;
        w_err_next     = r_err;
        w_finish       = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_guess_next = '0;
                w_busy_next  = 1'b0;
                if (start) begin
                    w_state_next   = S_SEARCH;
                    w_prefix_next  = '0;
                    w_bit_idx_next = IW'(WIDTH - 1);
                    w_guess_next   = MSB_ONE;
                    w_err_next     = 1'b0;
                    w_steps_next   = '0;
                    w_busy_next    = 1'b1;
                end
            end
            S_SEARCH: begin
                w_steps_next = r_steps + SW'(1);
                if (!w_legal || (cmp_lt && r_bit_idx == '0)) begin
                    // A "less than" on the last bit means the target exceeds prefix|1.
                    w_err_next    = 1'b1;
                    w_result_next = '0;
                    w_finish      = 1'b1;
                end else if (cmp_eq) begin
                    w_result_next = r_guess;
                    w_finish      = 1'b1;
                end else if (r_bit_idx == '0) begin
                    w_result_next = r_prefix;
                    w_finish      = 1'b1;
                end else begin
                    w_prefix_next  = w_kept_prefix;
                    w_bit_idx_next = w_idx_dec;
                    w_guess_next   = w_kept_prefix | w_bit_dec;
                end
                if (w_finish) begin
                    w_state_next = S_FIN;
                    w_done_next  = 1'b1;
                    w_busy_next  = 1'b0;
                    w_guess_next = '0;
                end
            end
            S_FIN: begin
                w_state_next = S_IDLE;
                w_busy_next  = 1'b0;
                w_guess_next = '0;
            end
            default: begin
                w_state_next = S_IDLE;
                w_busy_next  = 1'b0;
                w_guess_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_prefix  <= '0;
            r_bit_idx <= '0;
            r_guess   <= '0;
            r_result  <= '0;
            r_steps   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_prefix  <= w_prefix_next;
            r_bit_idx <= w_bit_idx_next;
            r_guess   <= w_guess_next;
            r_result  <= w_result_next;
            r_steps   <= w_steps_next;
            r_busy    <= w_busy_next;
            r_done    <= w_done_next;
            r_err     <= w_err_next;
        end
    end

    assign guess  = r_guess;
    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign err    = r_err;
    assign steps  = r_steps;

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: a behavioural comparator answers each trial value, and a
// bit-prefix arithmetic model predicts the guess sequence, result and step count.
module tb_sar_search;

    localparam int WIDTH = 4;
    localparam int SW    = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             cmp_gt = 1'b0, cmp_eq = 1'b0, cmp_lt = 1'b0;
    logic [WIDTH-1:0] guess;
    logic             busy, done, err;
    logic [WIDTH-1:0] result;
    logic [SW-1:0]    steps;

    int errors = 0;
    int checks = 0;

    int               mg[0:15];
    int               mn;
    logic [WIDTH-1:0] og[0:63];
    int               on_;
    bit               got_done;

    sar_search #(.WIDTH(WIDTH), .SW(SW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cmp_gt(cmp_gt), .cmp_eq(cmp_eq), .cmp_lt(cmp_lt),
        .guess(guess), .busy(busy), .done(done),
        .result(result), .err(err), .steps(steps)
    );

    always #5 clk = ~clk;

    // Trial k carries the target's top k bits followed by a single probe bit.
    task automatic model(input int t);
        mn = 0;
        for (int k = 0; k < WIDTH; k++) begin
            int hi;
            int g;
            hi = (t >> (WIDTH - k)) << (WIDTH - k);
            g  = hi | (1 << (WIDTH - 1 - k));
            mg[mn] = g;
            mn++;
            if (g == t) break;
        end
    endtask

    // Starts a search from IDLE; returns at the negedge of the first SEARCH cycle.
    task automatic kick();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Acts as the comparator until done is seen, busy drops, or max_n compares served.
    task automatic serve(input int t, input int force_at, input logic [2:0] fv,
                         input bit hold, input int pulse_at, input int max_n);
        on_ = 0;
        got_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1) begin
                got_done = 1'b1;
                break;
            end
            if (busy !== 1'b1 || on_ == max_n) break;
            og[on_] = guess;
            on_++;
            if (on_ == force_at) {cmp_gt, cmp_eq, cmp_lt} = fv;
            else {cmp_gt, cmp_eq, cmp_lt} = {guess > t, guess == t, guess < t};
            start = hold || (on_ == pulse_at);
            @(negedge clk);
        end
        {cmp_gt, cmp_eq, cmp_lt} = 3'b000;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (guess !== '0)  begin errors++; $display("FAIL reset_guess got=%0d exp=0", guess); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (result !== '0) begin errors++; $display("FAIL reset_result got=%0d exp=0", result); end
        checks++; if (err !== 1'b0)  begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (steps !== '0)  begin errors++; $display("FAIL reset_steps got=%0d exp=0", steps); end
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        $display("reset: guess=%0d busy=%b result=%0d steps=%0d", guess, busy, result, steps);
    endtask

    task automatic test_directed();
        int tl[4] = '{5, 8, 0, 15};
        for (int n = 0; n < 4; n++) begin
            model(tl[n]);
            kick();
            serve(tl[n], 0, 3'b000, 1'b0, 0, 99);
            checks++; if (!got_done) begin errors++; $display("FAIL dir_done tgt=%0d got=0 exp=1", tl[n]); end
            checks++; if (on_ != mn) begin errors++; $display("FAIL dir_ncmp tgt=%0d got=%0d exp=%0d", tl[n], on_, mn); end
            for (int i = 0; i < mn && i < on_; i++) begin
                checks++;
                if (og[i] !== WIDTH'(mg[i])) begin errors++; $display("FAIL dir_guess tgt=%0d idx=%0d got=%0d exp=%0d", tl[n], i, og[i], mg[i]); end
            end
            checks++; if (result !== WIDTH'(tl[n])) begin errors++; $display("FAIL dir_result got=%0d exp=%0d", result, tl[n]); end
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL dir_err tgt=%0d got=%b exp=0", tl[n], err); end
            checks++; if (steps !== SW'(mn)) begin errors++; $display("FAIL dir_steps tgt=%0d got=%0d exp=%0d", tl[n], steps, mn); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dir_fin_busy got=%b exp=0", busy); end
            @(negedge clk);
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL dir_done_pulse got=%b exp=0", done); end
            checks++; if (guess !== '0) begin errors++; $display("FAIL dir_idle_guess got=%0d exp=0", guess); end
            checks++; if (result !== WIDTH'(tl[n])) begin errors++; $display("FAIL dir_hold got=%0d exp=%0d", result, tl[n]); end
            $display("directed: tgt=%0d result=%0d steps=%0d err=%b", tl[n], result, steps, err);
        end
    endtask

    task automatic test_errors();
        int       tl[3] = '{5, 5, 0};
        int       fa[3] = '{2, 1, 4};
        logic [2:0] fv[3] = '{3'b101, 3'b000, 3'b001};
        for (int n = 0; n < 3; n++) begin
            model(tl[n]);
            kick();
            serve(tl[n], fa[n], fv[n], 1'b0, 0, 99);
            checks++; if (!got_done) begin errors++; $display("FAIL err_done case=%0d got=0 exp=1", n); end
            checks++; if (on_ != fa[n]) begin errors++; $display("FAIL err_ncmp case=%0d got=%0d exp=%0d", n, on_, fa[n]); end
            for (int i = 0; i < fa[n] && i < on_; i++) begin
                checks++;
                if (og[i] !== WIDTH'(mg[i])) begin errors++; $display("FAIL err_guess case=%0d idx=%0d got=%0d exp=%0d", n, i, og[i], mg[i]); end
            end
            checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_flag case=%0d got=%b exp=1", n, err); end
            checks++; if (result !== '0) begin errors++; $display("FAIL err_result case=%0d got=%0d exp=0", n, result); end
            checks++; if (steps !== SW'(fa[n])) begin errors++; $display("FAIL err_steps case=%0d got=%0d exp=%0d", n, steps, fa[n]); end
            @(negedge clk);
            checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_hold case=%0d got=%b exp=1", n, err); end
            $display("error: case=%0d tgt=%0d err=%b result=%0d steps=%0d", n, tl[n], err, result, steps);
        end
    endtask

    task automatic test_back_to_back();
        start = 1'b1;
        @(negedge clk);
        for (int t = 0; t < 16; t++) begin
            model(t);
            serve(t, 0, 3'b000, 1'b1, 0, 99);
            checks++; if (!got_done) begin errors++; $display("FAIL b2b_done tgt=%0d got=0 exp=1", t); end
            checks++; if (on_ != mn) begin errors++; $display("FAIL b2b_ncmp tgt=%0d got=%0d exp=%0d", t, on_, mn); end
            for (int i = 0; i < mn && i < on_; i++) begin
                checks++;
                if (og[i] !== WIDTH'(mg[i])) begin errors++; $display("FAIL b2b_guess tgt=%0d idx=%0d got=%0d exp=%0d", t, i, og[i], mg[i]); end
            end
            checks++; if (result !== WIDTH'(t)) begin errors++; $display("FAIL b2b_result got=%0d exp=%0d", result, t); end
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL b2b_err tgt=%0d got=%b exp=0", t, err); end
            if (t == 15) start = 1'b0;
            @(negedge clk);
            checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap tgt=%0d got busy=%b done=%b exp 0/0", t, busy, done); end
            $display("b2b: tgt=%0d result=%0d steps=%0d err=%b", t, result, steps, err);
            if (t < 15) begin
                @(negedge clk);
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart tgt=%0d got=%b exp=1", t, busy); end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        model(5);
        kick();
        serve(5, 0, 3'b000, 1'b0, 0, 2);
        checks++; if (on_ != 2) begin errors++; $display("FAIL mr_ncmp got=%0d exp=2", on_); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (guess !== '0) begin errors++; $display("FAIL mr_guess got=%0d exp=0", guess); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL mr_flags got busy=%b done=%b err=%b exp 0", busy, done, err); end
        checks++; if (result !== '0 || steps !== '0) begin errors++; $display("FAIL mr_regs got result=%0d steps=%0d exp 0", result, steps); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mr_no_done got=%b exp=0", done); end
        kick();
        serve(5, 0, 3'b000, 1'b0, 0, 99);
        checks++; if (!got_done || result !== 4'd5 || steps !== SW'(4) || err !== 1'b0) begin
            errors++; $display("FAIL mr_rerun got done=%b result=%0d steps=%0d err=%b exp 1/5/4/0", got_done, result, steps, err);
        end
        @(negedge clk);
        $display("mid_reset: rerun result=%0d steps=%0d", result, steps);
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            int t;
            int p;
            t = int'($urandom_range(0, 15));
            p = int'($urandom_range(1, 3));
            model(t);
            kick();
            serve(t, 0, 3'b000, 1'b0, p, 99);
            checks++; if (!got_done) begin errors++; $display("FAIL rnd_done tgt=%0d got=0 exp=1", t); end
            checks++; if (on_ != mn) begin errors++; $display("FAIL rnd_ncmp tgt=%0d got=%0d exp=%0d", t, on_, mn); end
            for (int i = 0; i < mn && i < on_; i++) begin
                checks++;
                if (og[i] !== WIDTH'(mg[i])) begin errors++; $display("FAIL rnd_guess tgt=%0d idx=%0d got=%0d exp=%0d", t, i, og[i], mg[i]); end
            end
            checks++; if (result !== WIDTH'(t) || err !== 1'b0 || steps !== SW'(mn)) begin
                errors++; $display("FAIL rnd_out tgt=%0d got result=%0d err=%b steps=%0d exp %0d/0/%0d", t, result, err, steps, t, mn);
            end
            start = 1'b0;
            @(negedge clk);
            $display("random: tgt=%0d pulse_at=%0d result=%0d steps=%0d", t, p, result, steps);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_errors();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
